// File: rtl/forward_pipe_pkg.sv
// Shared definitions for the forward-registered valid/ready pipeline.
// Holds the occupancy width helper and the data value stages take on reset.
`timescale 1ns/1ps
package forward_pipe_pkg;

  localparam logic RESET_DATA_BIT = 1'b0;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/forward_pipe_stage.sv
// One forward-registered pipeline stage: valid/data are flopped, ready is combinational.
// An empty stage always accepts, so bubbles collapse even while downstream stalls.
`timescale 1ns/1ps
module forward_pipe_stage
  import forward_pipe_pkg::*;
#(
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [L-1:0] data_in,
  output logic         ready_out,
  output logic         valid_out,
  output logic [L-1:0] data_out,
  input  logic         ready_in
);

  assign ready_out = ~valid_out | ready_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
    end else if (ready_out) begin
      valid_out <= valid_in;
    end
  end

  // Data only moves with a real beat, which keeps idle stages from toggling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= {L{RESET_DATA_BIT}};
    end else if (ready_out && valid_in) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/forward_pipe.sv
// Forward-registered valid/ready pipeline of DEPTH stages; ready_b reaches ready_f combinationally.
// Define FORWARD_PIPE_OCCUPANCY_EN to add the registered occupancy counter port.
`timescale 1ns/1ps
module forward_pipe
  import forward_pipe_pkg::*;
#(
  parameter int L     = 8,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          ready_f,
  input  logic                          valid_f,
  input  logic [L-1:0]                  data_f,
  input  logic                          ready_b,
  output logic                          valid_b,
  output logic [L-1:0]                  data_b
`ifdef FORWARD_PIPE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0]   occupancy
`endif
);

  // Index i is the input side of stage i; index DEPTH is the downstream boundary.
  logic         valid_c [DEPTH+1];
  logic [L-1:0] data_c  [DEPTH+1];
  logic         rdy     [DEPTH+1];

  assign valid_c[0]  = valid_f;
  assign data_c[0]   = data_f;
  assign rdy[DEPTH]  = ready_b;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    forward_pipe_stage #(
      .L(L)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .valid_in (valid_c[i]),
      .data_in  (data_c[i]),
      .ready_out(rdy[i]),
      .valid_out(valid_c[i+1]),
      .data_out (data_c[i+1]),
      .ready_in (rdy[i+1])
    );
  end

  assign ready_f = rdy[0];
  assign valid_b = valid_c[DEPTH];
  assign data_b  = data_c[DEPTH];

`ifdef FORWARD_PIPE_OCCUPANCY_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = valid_f & ready_f;
  assign out_xfer = valid_b & ready_b;

  // Tracks the number of valid stages; simultaneous in and out cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_forward_pipe.sv
// Scoreboard bench for forward_pipe: directed scenarios on DEPTH=2, random traffic on DEPTH=2 and DEPTH=1.
// The reference model is a queue of beats in flight; ready_f and occupancy follow from its size.
`timescale 1ns/1ps
module tb_forward_pipe;

  localparam int L  = 8;
  localparam int D2 = 2;
  localparam int D1 = 1;

  logic         clk;
  logic         rst;

  logic         ready_f,  valid_f,  ready_b,  valid_b;
  logic [L-1:0] data_f,   data_b;
  logic         ready_f1, valid_f1, ready_b1, valid_b1;
  logic [L-1:0] data_f1,  data_b1;
`ifdef FORWARD_PIPE_OCCUPANCY_EN
  logic [1:0]   occupancy;
  logic [0:0]   occupancy1;
`endif

  int checks = 0;
  int errors = 0;

  logic [L-1:0] sb_q  [$];
  logic [L-1:0] sb_q1 [$];

  forward_pipe #(.L(L), .DEPTH(D2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ready_f  (ready_f),
    .valid_f  (valid_f),
    .data_f   (data_f),
    .ready_b  (ready_b),
    .valid_b  (valid_b),
    .data_b   (data_b)
`ifdef FORWARD_PIPE_OCCUPANCY_EN
    ,
    .occupancy(occupancy)
`endif
  );

  forward_pipe #(.L(L), .DEPTH(D1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .ready_f  (ready_f1),
    .valid_f  (valid_f1),
    .data_f   (data_f1),
    .ready_b  (ready_b1),
    .valid_b  (valid_b1),
    .data_b   (data_b1)
`ifdef FORWARD_PIPE_OCCUPANCY_EN
    ,
    .occupancy(occupancy1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [L-1:0] d, input logic rb);
    @(posedge clk);
    #1;
    valid_f = v;
    data_f  = d;
    ready_b = rb;
  endtask

  // Monitor for the DEPTH=2 instance: model checks, then pop on out-transfer, push on in-transfer.
  always @(negedge clk) begin
    int cnt;
    if (!rst) begin
      sb_q.delete();
      checkOutput("rst_valid_b", valid_b, 0);
      checkOutput("rst_data_b", data_b, 0);
      checkOutput("rst_ready_f", ready_f, 1);
    end else begin
      cnt = sb_q.size();
      checkOutput("model_ready_f", ready_f, 32'((cnt < D2) || ready_b));
      if (cnt == 0) checkOutput("empty_valid_b", valid_b, 0);
      if (cnt == D2) checkOutput("full_valid_b", valid_b, 1);
`ifdef FORWARD_PIPE_OCCUPANCY_EN
      checkOutput("occupancy", occupancy, cnt);
`endif
      if (valid_b && ready_b) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_extra_beat: got 0x%0h, expected no beat at %0t", data_b, $time);
        end else begin
          checkOutput("sb_data", data_b, sb_q.pop_front());
        end
      end
      if (valid_f && ready_f) sb_q.push_back(data_f);
    end
  end

  // Monitor for the DEPTH=1 instance, same model with its own queue.
  always @(negedge clk) begin
    int cnt;
    if (!rst) begin
      sb_q1.delete();
      checkOutput("rst1_valid_b", valid_b1, 0);
    end else begin
      cnt = sb_q1.size();
      checkOutput("model1_ready_f", ready_f1, 32'((cnt < D1) || ready_b1));
      checkOutput("model1_valid_b", valid_b1, 32'(cnt == D1));
`ifdef FORWARD_PIPE_OCCUPANCY_EN
      checkOutput("occupancy1", occupancy1, cnt);
`endif
      if (valid_b1 && ready_b1) begin
        if (sb_q1.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb1_extra_beat: got 0x%0h, expected no beat at %0t", data_b1, $time);
        end else begin
          checkOutput("sb1_data", data_b1, sb_q1.pop_front());
        end
      end
      if (valid_f1 && ready_f1) sb_q1.push_back(data_f1);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    rst = 1'b0; valid_f = 1'b0; data_f = '0; ready_b = 1'b0;
    valid_f1 = 1'b0; data_f1 = '0; ready_b1 = 1'b0;
    #2;
    checkOutput("init_valid_b", valid_b, 0);
    checkOutput("init_data_b", data_b, 0);
    checkOutput("init_ready_f", ready_f, 1);
    #20 rst = 1'b1;

    $display("[TB] streaming");
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, L'(i), 1'b1);
      @(negedge clk);
      checkOutput("stream_ready_f", ready_f, 1);
      checkOutput("stream_valid_b", valid_b, 32'(i >= 3));
      if (i >= 3) checkOutput("stream_data_b", data_b, i - 2);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("stream_drained", valid_b, 0);

    $display("[TB] fill and stall");
    applyStimulus(1'b1, 8'hA1, 1'b0);
    @(negedge clk); checkOutput("fill_a1_ready_f", ready_f, 1);
    applyStimulus(1'b1, 8'hA2, 1'b0);
    @(negedge clk); checkOutput("fill_a2_ready_f", ready_f, 1);
    applyStimulus(1'b1, 8'hA3, 1'b0);
    @(negedge clk);
    checkOutput("fill_a3_ready_f", ready_f, 0);
    checkOutput("fill_data_b", data_b, 8'hA1);
`ifdef FORWARD_PIPE_OCCUPANCY_EN
    checkOutput("fill_occupancy", occupancy, 2);
`endif
    applyStimulus(1'b1, 8'hA3, 1'b0);
    @(negedge clk); checkOutput("hold_a3_ready_f", ready_f, 0);
    applyStimulus(1'b1, 8'hA3, 1'b1);
    @(negedge clk);
    checkOutput("release_ready_f", ready_f, 1);
    checkOutput("release_a1", data_b, 8'hA1);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk); checkOutput("release_a2", data_b, 8'hA2);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk); checkOutput("release_a3", data_b, 8'hA3);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk); checkOutput("release_empty", valid_b, 0);

    $display("[TB] bubble collapse");
    applyStimulus(1'b1, 8'h55, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b0);
    @(negedge clk);
    checkOutput("bubble_ready_f", ready_f, 1);
    checkOutput("bubble_data_b", data_b, 8'h55);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("bubble_full_ready_f", ready_f, 0);
    checkOutput("bubble_full_valid_b", valid_b, 1);
    checkOutput("bubble_full_data_b", data_b, 8'h55);

    $display("[TB] simultaneous in/out when full");
    applyStimulus(1'b1, 8'h77, 1'b1);
    @(negedge clk); checkOutput("simul_ready_f", ready_f, 1);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("simul_data_b", data_b, 8'h66);
`ifdef FORWARD_PIPE_OCCUPANCY_EN
    checkOutput("simul_occupancy", occupancy, 2);
`endif
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk); checkOutput("simul_data_77", data_b, 8'h77);
    applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_valid_b", valid_b, 0);
    checkOutput("midrst_data_b", data_b, 0);
    checkOutput("midrst_ready_f", ready_f, 1);
`ifdef FORWARD_PIPE_OCCUPANCY_EN
    checkOutput("midrst_occupancy", occupancy, 0);
`endif
    @(negedge clk);
    #2 rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk); checkOutput("postrst_valid_b", valid_b, 0);

    $display("[TB] random traffic DEPTH=2");
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      acc = valid_f && ready_f;
      @(posedge clk);
      #1;
      if (!valid_f || acc) begin
        valid_f = ($urandom_range(0, 3) != 0);
        data_f  = L'($urandom);
      end
      ready_b = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
    end
    valid_f = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("random_drain", sb_q.size(), 0);

    $display("[TB] random traffic DEPTH=1");
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      acc = valid_f1 && ready_f1;
      @(posedge clk);
      #1;
      if (!valid_f1 || acc) begin
        valid_f1 = ($urandom_range(0, 1) != 0);
        data_f1  = L'($urandom);
      end
      ready_b1 = ($urandom_range(0, 1) != 0);
    end
    @(posedge clk);
    #1;
    valid_f1 = 1'b0;
    ready_b1 = 1'b1;
    for (int i = 0; i < 3; i++) @(posedge clk);
    @(negedge clk);
    checkOutput("random1_drain", sb_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/forward_pipe.md
# forward_pipe

Forward-registered valid/ready pipeline of parameterizable depth, the counterpart of our backward skid buffer: it registers the valid and data path and leaves ready combinational. It is inserted where the forward (valid/data) timing path must be cut while the ready path can stay combinational. Empty stages absorb bubbles, so throughput stays at one beat per cycle. A stalled downstream fills the pipe before upstream sees back-pressure.

## Interface
- L, 8, data width in bits (≥1)
- DEPTH, 2, number of register stages (≥1; 0 is illegal)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- ready_f  output  1  pipe accepts a beat from upstream this cycle (combinational)
- valid_f  input  1  upstream beat valid
- data_f  input  L  upstream beat data
- ready_b  input  1  downstream accepts a beat
- valid_b  output  1  downstream beat valid (registered)
- data_b  output  L  downstream beat data (registered)
- occupancy  output  $clog2(DEPTH+1)  valid stages held; present only with FORWARD_PIPE_OCCUPANCY_EN

## Operation
- Stage i holds valid_q[i] and data_q[i]. Stage 0 faces upstream. Stage DEPTH-1 drives valid_b and data_b.
- Stage ready: rdy[i] = ~valid_q[i] | rdy[i+1], with rdy[DEPTH] = ready_b. ready_f = rdy[0].
- When rdy[i]=1 on a clock edge, valid_q[i] loads the valid of the previous stage (valid_f for stage 0).
- data_q[i] loads the previous stage's data only when that valid is 1. Otherwise data_q[i] holds, to limit toggling.
- When rdy[i]=0, the stage holds both valid_q[i] and data_q[i].
- Transfer in: valid_f & ready_f. Transfer out: valid_b & ready_b.
- Beats leave in arrival order. No beat is dropped or duplicated.
- Bubble collapse: an empty stage accepts from the previous stage even while ready_b=0.
- Full: all valid_q=1 and ready_b=0, so ready_f=0. Upstream must hold valid_f and data_f stable until accepted.
- Full with ready_b=1: every stage advances. ready_f=1, so in and out transfer in the same cycle.
- Empty: valid_b=0 and ready_f=1 regardless of ready_b.
- data_b is don't-care while valid_b=0. It retains the last loaded value.

## Timing
- Reset (rst=0, asynchronous): all valid_q=0 and all data_q=0.
  - During reset: valid_b=0, data_b=0, occupancy=0.
  - ready_f=1 during reset because it is combinational from the empty stages.
- Any beats in flight when rst asserts mid-operation are discarded. Operation resumes on the first rising clk after rst deasserts.
- Latency: a beat accepted at edge k appears on valid_b after edge k+DEPTH-1, assuming no stall. This is DEPTH registers from input to output.
- Throughput: 1 beat/cycle sustained when ready_b=1.
- ready_f has a combinational path from ready_b through DEPTH OR stages. This is the accepted trade-off of this block.
- valid_b and data_b have no combinational path from any input.

## Configuration
- FORWARD_PIPE_OCCUPANCY_EN defined: the occupancy port exists.
  - It is a registered counter, reset to 0.
  - It gains +1 on an in-transfer only, −1 on an out-transfer only, and is unchanged on both or neither.
  - It always equals the popcount of valid_q.
  - It never exceeds DEPTH and never underflows.
- Undefined: no occupancy port and no counter logic. All other behaviour is identical.

## Structure
- Shared package forward_pipe_pkg holds the occupancy width function (clog2 of DEPTH+1) and the reset data constant (all zeros).
- Sub-module forward_pipe_stage: one register stage with ports clk, rst, valid_in, data_in, ready_out, valid_out, data_out, ready_in.
- The top level instantiates DEPTH stages in a generate loop. It also contains the optional occupancy counter.

## Test plan (L=8, DEPTH=2 unless noted)
- Reset: assert rst mid-stream with 2 beats held -> valid_b=0, data_b=0, ready_f=1, occupancy=0 immediately, without waiting for clk.
- Streaming: send 0x01..0x10 back-to-back with ready_b=1 -> 0x01 is on valid_b one cycle after acceptance, then one beat per cycle in order; ready_f stays 1 throughout.
- Fill/stall: ready_b=0, send 0xA1, 0xA2, 0xA3 -> 0xA1 and 0xA2 are accepted; ready_f=0 while 0xA3 is held; occupancy=2.
  - Then raise ready_b=1 -> 0xA1, 0xA2, 0xA3 exit on consecutive cycles.
- Bubble collapse: hold ready_b=0; send 0x55 into the empty pipe, idle one cycle, then send 0x66 -> 0x66 is accepted, valid_b=1 with data_b=0x55, ready_f=0.
- Simultaneous in/out when full: ready_b=1 with valid_f=1 -> in and out transfer in the same cycle; occupancy stays at DEPTH.
- DEPTH=1, random valid_f and ready_b over 10k cycles -> a scoreboard shows in-order, lossless delivery with no duplicates; occupancy matches the valid-bit popcount every cycle.
